cntr_bank: RTL
==============

Name: cntr_bank

Overview:
- Bank of NCH independent programmable interval counters.
- All channels share one clock-enable prescaler.
- Each channel has a selectable direction (up/down) and mode (one-shot/auto-reload).
- Used by the matrix driver for row dwell, PWM slot and refresh timing; replaces the ad-hoc single-purpose up/down counters.

Parameters:
- NCH, 4, number of channels.
- W, 11, counter and period width per channel.
- PRE_W, 8, prescaler width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- prescale  in  PRE_W  tick every prescale+1 clk cycles; 0 = every cycle.
- en  in  NCH  per-channel count enable; low holds the count.
- load  in  NCH  per-channel load strobe.
- load_val  in  NCH*W  per-channel period; channel i is bits [i*W +: W].
- dir  in  NCH  1 = up, 0 = down.
- reload  in  NCH  1 = auto-reload, 0 = one-shot.
- cnt  out  NCH*W  current counts, packed the same way as load_val.
- busy  out  NCH  channel running.
- tc  out  NCH  terminal-count pulse, one clk wide.
- tick  out  1  prescaler tick, for observation and debug.

Behaviour:
- Reset (reset==0 at posedge), all registers cleared:
  - prescaler count = 0, tick = 0.
  - period = 0, cnt = 0, busy = 0, tc = 0.
- Reset has priority over everything. Asserting it mid-run aborts all channels; no tc is generated.
- Prescaler:
  - pre_cnt increments each clk.
  - When pre_cnt == prescale: tick = 1 for that cycle (combinational from pre_cnt), and pre_cnt wraps to 0.
  - If prescale changes while pre_cnt > prescale, pre_cnt wraps to 0 on the next clk with no tick.
- Per channel, two states: IDLE (busy=0) and RUN (busy=1).
- load[i] = 1 (any state), at the next posedge:
  - period[i] <= load_val[i].
  - cnt[i] <= dir[i] ? 0 : load_val[i].
  - busy <= 1, tc <= 0.
  - Load wins over a coincident tick: no count step, no tc.
- RUN, tick & en[i] & !load[i]:
  - Terminal value is period when up, 0 when down.
  - If cnt != terminal: cnt steps by ±1.
  - If cnt == terminal: tc[i] <= 1 for the next cycle only.
    - Auto-reload: cnt <= start value (0 for up, period for down), stays in RUN.
    - One-shot: cnt holds terminal, busy <= 0 (IDLE).
- Interval between tc pulses is (period+1) ticks.
- period = 0: tc fires on every tick (auto-reload) or on the first tick (one-shot).
- en low or no tick: cnt, busy and period hold; tc = 0.
- IDLE: cnt holds and ignores tick; only load leaves IDLE.
- dir changed mid-run: takes effect at the next tick, with terminal evaluated under the new dir. cnt ≤ period always holds, so no overflow or wrap past the range is possible.
- All arithmetic is unsigned W-bit.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- Outputs are registered except tick.

Decomposition:
- Package cntr_pkg holds:
  - typedef cnt_dir_e {CNT_DOWN=0, CNT_UP=1}.
  - typedef cnt_mode_e {CNT_ONESHOT=0, CNT_RELOAD=1}.
  - typedef ch_state_e {CH_IDLE, CH_RUN}.
- Sub-module tick_gen (prescaler: clk, reset, prescale -> tick).
- The channel logic sits in a generate loop inside cntr_bank.

Test Plan:
- Reset, then prescale=0, ch0 down, reload=1, load_val=3, en=1:
  - cnt sequence is 3,2,1,0,3...
  - tc0 pulses every 4 clks, one cycle wide, coinciding with cnt=3 after reload.
- ch1 up, one-shot, load_val=2, prescale=2:
  - cnt steps 0→1→2 every 3 clks.
  - One tc1 pulse, then busy1=0 and cnt1 holds 2 indefinitely.
- Load asserted on a tick cycle while cnt=0 (down, reload):
  - No tc; cnt = new load_val next cycle.
- en low for 5 ticks mid-count (cnt=5):
  - cnt stays 5 and no tc; counting resumes from 5 when en returns.
- reset pulled low while ch0 is running with cnt=7:
  - Next cycle cnt=0, busy=0, tc=0, tick=0.
  - No tc afterwards until a new load.
- period=0, auto-reload, prescale=0:
  - tc high every cycle after the load; cnt stays 0.
  - All 4 channels loaded simultaneously with different values count independently.

Source files
------------

// File: rtl/cntr_pkg.sv
// cntr_pkg: shared types and default sizes for the counter bank
package cntr_pkg;
  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
  typedef enum logic {CNT_ONESHOT = 1'b0, CNT_RELOAD = 1'b1} cnt_mode_e;
  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_e;
  localparam int NCH_DEF = 4;
  localparam int W_DEF = 11;
  localparam int PRE_W_DEF = 8;
endpackage

// File: rtl/cntr_bank_if.sv
// cntr_bank_if: control and status bundle between a counter bank and its user
interface cntr_bank_if import cntr_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int W = W_DEF,
  parameter int PRE_W = PRE_W_DEF
) ();
  logic [PRE_W-1:0] prescale;
  logic [NCH-1:0] en;
  logic [NCH-1:0] load;
  logic [NCH*W-1:0] load_val;
  logic [NCH-1:0] dir;
  logic [NCH-1:0] reload;
  logic [NCH*W-1:0] cnt;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] tc;
  logic tick;
  modport master (output prescale, en, load, load_val, dir, reload, input cnt, busy, tc, tick);
  modport slave (input prescale, en, load, load_val, dir, reload, output cnt, busy, tc, tick);
endinterface

// File: rtl/cntr_bank_tick_gen.sv
// tick_gen: shared prescaler producing one tick every prescale+1 clocks
module tick_gen import cntr_pkg::*; #(
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic [PRE_W-1:0] i_prescale,
  output logic o_tick
);
  logic [PRE_W-1:0] r_pre_cnt;
  // Wrap at prescale; a count left above a newly lowered prescale also wraps, without ticking
  always_ff @(posedge clk)
    r_pre_cnt <= (!reset || r_pre_cnt >= i_prescale) ? '0 : r_pre_cnt + PRE_W'(1);
  assign o_tick = reset && (r_pre_cnt == i_prescale);
endmodule

// File: rtl/cntr_bank.sv
// cntr_bank: bank of independent up/down one-shot/auto-reload interval counters
module cntr_bank import cntr_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int W = W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input logic clk,
  input logic reset,
  cntr_bank_if.slave s
);
  logic w_tick;
  tick_gen #(.PRE_W(PRE_W)) u_tick_gen (
    .clk(clk),
    .reset(reset),
    .i_prescale(s.prescale),
    .o_tick(w_tick)
  );
  assign s.tick = w_tick;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e r_state, w_state;
    cnt_dir_e w_dir;
    cnt_mode_e w_mode;
    logic [W-1:0] r_period, w_period, r_cnt, w_cnt, w_val, w_term, w_start;
    logic r_tc, w_tc, w_step, w_at_term;
    assign w_dir = cnt_dir_e'(s.dir[i]);
    assign w_mode = cnt_mode_e'(s.reload[i]);
    assign w_val = s.load_val[i*W +: W];
    // Next state: load beats a tick; a step at the terminal value emits tc and reloads or stops
    always_comb begin
      w_term = (w_dir == CNT_UP) ? r_period : '0;
      w_start = (w_dir == CNT_UP) ? '0 : r_period;
      w_step = (r_state == CH_RUN) && w_tick && s.en[i] && !s.load[i];
      w_at_term = r_cnt == w_term;
      w_period = s.load[i] ? w_val : r_period;
      w_cnt = s.load[i] ? ((w_dir == CNT_UP) ? '0 : w_val) :
              !w_step ? r_cnt :
              !w_at_term ? ((w_dir == CNT_UP) ? r_cnt + W'(1) : r_cnt - W'(1)) :
              (w_mode == CNT_RELOAD) ? w_start : r_cnt;
      w_state = s.load[i] ? CH_RUN :
                (w_step && w_at_term && w_mode == CNT_ONESHOT) ? CH_IDLE : r_state;
      w_tc = w_step && w_at_term;
    end
    // Channel registers, all cleared by reset
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state <= CH_IDLE;
        r_period <= '0;
        r_cnt <= '0;
        r_tc <= 1'b0;
      end else begin
        r_state <= w_state;
        r_period <= w_period;
        r_cnt <= w_cnt;
        r_tc <= w_tc;
      end
    end
    assign s.cnt[i*W +: W] = r_cnt;
    assign s.busy[i] = r_state == CH_RUN;
    assign s.tc[i] = r_tc;
  end
endmodule
